// File: rtl/mux_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl_if
// Connects the scan sequencer to the downstream 4:1 mux and to its requester.
//   start  scan request from the requester
//   Y      output of the downstream mux
//   A      mux select [0:1]; A[0] has weight 1, A[1] has weight 2
//   E      mux disable, 1 forces Y=0
//   busy   high while a scan is running
//   done   one-cycle pulse closing each scan
//   S      S[k] = Y sampled on channel k during the most recent scan
// The master modport is the sequencer side; slave is the mux/requester side.
// ---------------------------------------------------------------------------
interface mux_scan_ctrl_if;
  logic       start;
  logic       Y;
  logic [0:1] A;
  logic       E;
  logic       busy;
  logic       done;
  logic [0:3] S;

  modport master (
    input  start, Y,
    output A, E, busy, done, S
  );

  modport slave (
    output start, Y,
    input  A, E, busy, done, S
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
// Steps the select of a 4:1 mux (with active-high disable) through channels
// 0..3, holding each channel for DWELL cycles and sampling Y on the last
// cycle of each dwell. The four samples are presented on S and a one-cycle
// done pulse closes every scan. The mux is held disabled whenever no scan
// is running.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_scan_ctrl_if.master (start, Y, A, E, busy, done, S)
//   chg    only with MUX_SCAN_CHG_EN defined: high in the DONE cycle when
//          the final S differs from the previous scan's S
//
// Parameters
//   DWELL  cycles spent on each channel (>= 1)
//
// Optional feature macro: MUX_SCAN_CHG_EN
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int DWELL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_scan_ctrl_if.master    bus
`ifdef MUX_SCAN_CHG_EN
  ,
  output logic               chg
`endif
);

  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    ch, ch_d;      // channel number, bit 0 has weight 1
  logic [0:3]    s_q, s_d, s_new;
  logic          e_q, e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef MUX_SCAN_CHG_EN
  logic [0:3]    prev, prev_d;
  logic          chg_q, chg_d;
`endif

  // Current S with this cycle's sample merged in; the channel-3 sample is
  // part of the final S on the SCAN->DONE edge.
  always_comb begin
    s_new     = s_q;
    s_new[ch] = bus.Y;
  end

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ch_d    = ch;
    s_d     = s_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MUX_SCAN_CHG_EN
    prev_d  = prev;
    chg_d   = 1'b0;
`endif

    case (state)
      IDLE: begin
        e_d    = 1'b1;
        busy_d = 1'b0;
        ch_d   = 2'd0;
        if (bus.start) begin
          state_d = SCAN;
          e_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          s_d     = '0;
        end
      end

      SCAN: begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
          s_d   = s_new;
          cnt_d = '0;
          if (ch != 2'd3) begin
            ch_d = ch + 2'd1;
          end else begin
            // Last channel sampled: disable the mux on the same edge that
            // raises done.
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            e_d     = 1'b1;
            ch_d    = 2'd0;
`ifdef MUX_SCAN_CHG_EN
            chg_d   = (s_new != prev);
            prev_d  = s_new;
`endif
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        e_d     = 1'b1;
        busy_d  = 1'b0;
        ch_d    = 2'd0;
      end

      default: begin
        state_d = IDLE;
        e_d     = 1'b1;
        busy_d  = 1'b0;
        ch_d    = 2'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; reset is checked only on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ch     <= 2'd0;
      s_q    <= '0;
      e_q    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MUX_SCAN_CHG_EN
      prev   <= '0;
      chg_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ch     <= ch_d;
      s_q    <= s_d;
      e_q    <= e_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef MUX_SCAN_CHG_EN
      prev   <= prev_d;
      chg_q  <= chg_d;
`endif
    end
  end

  assign bus.A[0] = ch[0];
  assign bus.A[1] = ch[1];
  assign bus.E    = e_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
`ifdef MUX_SCAN_CHG_EN
  assign chg      = chg_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Bench for mux_scan_ctrl: dut_a uses DWELL=3, dut_b uses DWELL=1. Each DUT
// drives a behavioural 4:1 mux (Y = E ? 0 : I[channel]) built in the bench.
// Cycle n is the interval after the n-th rising edge counted from the edge
// that samples start (cycle 0). Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_ctrl_if if_a ();
  mux_scan_ctrl_if if_b ();

  logic [0:3] i_a, i_b;
  logic [1:0] ch_a, ch_b;

  assign ch_a   = {if_a.A[1], if_a.A[0]};
  assign ch_b   = {if_b.A[1], if_b.A[0]};
  assign if_a.Y = if_a.E ? 1'b0 : i_a[ch_a];
  assign if_b.Y = if_b.E ? 1'b0 : i_b[ch_b];

`ifdef MUX_SCAN_CHG_EN
  logic chg_a, chg_b;
`endif

  mux_scan_ctrl #(.DWELL(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
`ifdef MUX_SCAN_CHG_EN
    ,
    .chg   (chg_a)
`endif
  );

  mux_scan_ctrl #(.DWELL(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
`ifdef MUX_SCAN_CHG_EN
    ,
    .chg   (chg_b)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [0:3] i;
    logic [0:3] exp_s;
    logic       exp_chg;   // expected chg in DONE, prev starting at 4'b0000
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full DWELL=3 scan on dut_a, starting from IDLE.
  task automatic run_scan(input logic [0:3] i, input logic [0:3] exp_s,
                          input logic exp_chg);
    i_a = i;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("scan busy c%0d", c), {31'd0, if_a.busy}, 32'd1);
      check($sformatf("scan E c%0d", c), {31'd0, if_a.E}, 32'd0);
      check($sformatf("scan chan c%0d", c), {30'd0, ch_a}, (c - 1) / 3);
      check($sformatf("scan done c%0d", c), {31'd0, if_a.done}, 32'd0);
      if (c == 1) check("scan S cleared", {28'd0, if_a.S}, 32'd0);
`ifdef MUX_SCAN_CHG_EN
      check($sformatf("scan chg c%0d", c), {31'd0, chg_a}, 32'd0);
`endif
      tick();
    end
    check("done c13", {31'd0, if_a.done}, 32'd1);
    check("busy c13", {31'd0, if_a.busy}, 32'd0);
    check("E c13", {31'd0, if_a.E}, 32'd1);
    check("chan c13", {30'd0, ch_a}, 32'd0);
    check("S c13", {28'd0, if_a.S}, {28'd0, exp_s});
`ifdef MUX_SCAN_CHG_EN
    check("chg c13", {31'd0, chg_a}, {31'd0, exp_chg});
`endif
    tick();
    check("done c14", {31'd0, if_a.done}, 32'd0);
    check("busy c14", {31'd0, if_a.busy}, 32'd0);
    check("E c14", {31'd0, if_a.E}, 32'd1);
    check("S hold c14", {28'd0, if_a.S}, {28'd0, exp_s});
`ifdef MUX_SCAN_CHG_EN
    check("chg c14", {31'd0, chg_a}, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{i: 4'b1010, exp_s: 4'b1010, exp_chg: 1'b1};
    vecs[1] = '{i: 4'b0110, exp_s: 4'b0110, exp_chg: 1'b1};
    vecs[2] = '{i: 4'b0110, exp_s: 4'b0110, exp_chg: 1'b0};
    vecs[3] = '{i: 4'b0001, exp_s: 4'b0001, exp_chg: 1'b1};
    vecs[4] = '{i: 4'b0000, exp_s: 4'b0000, exp_chg: 1'b1};
    vecs[5] = '{i: 4'b0000, exp_s: 4'b0000, exp_chg: 1'b0};
    vecs[6] = '{i: 4'b1111, exp_s: 4'b1111, exp_chg: 1'b1};

    // Reset held for two edges with start high: nothing may be accepted.
    rst_n      = 1'b0;
    i_a        = 4'b1111;
    i_b        = 4'b1111;
    if_a.start = 1'b1;
    if_b.start = 1'b1;
    @(negedge clk);
    tick();
    tick();
    check("rst chan", {30'd0, ch_a}, 32'd0);
    check("rst E", {31'd0, if_a.E}, 32'd1);
    check("rst busy", {31'd0, if_a.busy}, 32'd0);
    check("rst done", {31'd0, if_a.done}, 32'd0);
    check("rst S", {28'd0, if_a.S}, 32'd0);
    check("rst busy b", {31'd0, if_b.busy}, 32'd0);
`ifdef MUX_SCAN_CHG_EN
    check("rst chg", {31'd0, chg_a}, 32'd0);
`endif
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    rst_n      = 1'b1;
    tick();
    check("idle after rst", {31'd0, if_a.busy}, 32'd0);

    // Table-driven single scans.
    for (int v = 0; v < 7; v++) run_scan(vecs[v].i, vecs[v].exp_s, vecs[v].exp_chg);

    // Start held high: back-to-back scans with one IDLE cycle in between.
    i_a = 4'b0110;
    if_a.start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      check($sformatf("held done c%0d", c), {31'd0, if_a.done},
            {31'd0, (c == 13 || c == 27)});
      check($sformatf("held busy c%0d", c), {31'd0, if_a.busy},
            {31'd0, ((c >= 1 && c <= 12) || (c >= 15 && c <= 26))});
      if (c == 13 || c == 27) check($sformatf("held S c%0d", c), {28'd0, if_a.S}, 32'h6);
      if_a.start = (c <= 26);
      tick();
    end

    // Start pulses during SCAN and DONE are ignored.
    i_a = 4'b1100;
    if_a.start = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("ign done c%0d", c), {31'd0, if_a.done}, {31'd0, (c == 13)});
      check($sformatf("ign busy c%0d", c), {31'd0, if_a.busy}, {31'd0, (c <= 12)});
      if_a.start = (c == 5 || c == 13);
      tick();
    end
    if_a.start = 1'b0;

    // Reset in the middle of a scan, then a fresh start at cycle 9.
    i_a = 4'b1111;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      check($sformatf("abort done c%0d", c), {31'd0, if_a.done}, {31'd0, (c == 22)});
      if (c == 7) begin
        check("abort chan", {30'd0, ch_a}, 32'd0);
        check("abort E", {31'd0, if_a.E}, 32'd1);
        check("abort busy", {31'd0, if_a.busy}, 32'd0);
        check("abort S", {28'd0, if_a.S}, 32'd0);
      end
      if (c >= 10 && c <= 21) check($sformatf("abort busy c%0d", c), {31'd0, if_a.busy}, 32'd1);
      if (c == 22) check("abort S final", {28'd0, if_a.S}, 32'hF);
`ifdef MUX_SCAN_CHG_EN
      check($sformatf("abort chg c%0d", c), {31'd0, chg_a}, {31'd0, (c == 22)});
`endif
      rst_n      = (c != 6);
      if_a.start = (c == 9);
      tick();
    end
    rst_n      = 1'b1;
    if_a.start = 1'b0;

    // Change detection across scans (prev is 4'b1111 here).
    run_scan(4'b1010, 4'b1010, 1'b1);
    run_scan(4'b1010, 4'b1010, 1'b0);
    run_scan(4'b0011, 4'b0011, 1'b1);

    // DWELL=1 instance.
    i_b = 4'b0001;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        check($sformatf("d1 chan c%0d", c), {30'd0, ch_b}, c - 1);
        check($sformatf("d1 busy c%0d", c), {31'd0, if_b.busy}, 32'd1);
      end
      check($sformatf("d1 done c%0d", c), {31'd0, if_b.done}, {31'd0, (c == 5)});
      if (c == 5) check("d1 S", {28'd0, if_b.S}, 32'h1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
